// File: rtl/pipe_stage_skid.sv
// Elastic valid/ready pipeline register with optional two-entry skid buffer,
// flush, empty-slot control clearing and a saturating stall counter.
module pipe_stage_skid #(
    parameter int DATA_W = 100,
    parameter int CTRL_W = 12,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              up_valid,
    output logic              up_ready,
    input  logic [CTRL_W-1:0] up_ctrl,
    input  logic [DATA_W-1:0] up_data,
    output logic              dn_valid,
    input  logic              dn_ready,
    output logic [CTRL_W-1:0] dn_ctrl,
    output logic [DATA_W-1:0] dn_data,
    input  logic              flush,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              m_valid_q, m_valid_d;
    logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic              s_valid_q, s_valid_d;
    logic [CTRL_W-1:0] s_ctrl_q, s_ctrl_d;
    logic [DATA_W-1:0] s_data_q, s_data_d;
    logic              up_ready_q, up_ready_d;
    logic [1:0]        occupancy_q, occupancy_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic              up_fire, dn_fire;

    // Skid variant breaks the dn_ready -> up_ready path with a register
    generate
        if (SKID != 0) begin : g_skid
            assign up_ready = up_ready_q;
        end else begin : g_pass
            assign up_ready = dn_ready | ~m_valid_q;
        end
    endgenerate

    assign up_fire   = up_valid & up_ready;
    assign dn_fire   = m_valid_q & dn_ready;
    assign dn_valid  = m_valid_q;
    assign dn_ctrl   = m_ctrl_q;
    assign dn_data   = m_data_q;
    assign occupancy = occupancy_q;
    assign stall_cnt = stall_cnt_q;

    always_comb begin
        m_valid_d = m_valid_q;
        m_ctrl_d  = m_ctrl_q;
        m_data_d  = m_data_q;
        s_valid_d = s_valid_q;
        s_ctrl_d  = s_ctrl_q;
        s_data_d  = s_data_q;
        if (flush) begin
            m_valid_d = 1'b0;
            m_ctrl_d  = '0;
            s_valid_d = 1'b0;
            s_ctrl_d  = '0;
        end else if (SKID != 0) begin
            if (s_valid_q) begin
                if (dn_fire) begin
                    m_valid_d = 1'b1;
                    m_ctrl_d  = s_ctrl_q;
                    m_data_d  = s_data_q;
                    s_valid_d = 1'b0;
                    s_ctrl_d  = '0;
                end
            end else if (!m_valid_q || dn_fire) begin
                if (up_fire) begin
                    m_valid_d = 1'b1;
                    m_ctrl_d  = up_ctrl;
                    m_data_d  = up_data;
                end else if (dn_fire) begin
                    m_valid_d = 1'b0;
                    m_ctrl_d  = '0;
                end
            end else if (up_fire) begin
                s_valid_d = 1'b1;
                s_ctrl_d  = up_ctrl;
                s_data_d  = up_data;
            end
        end else begin
            if (up_fire) begin
                m_valid_d = 1'b1;
                m_ctrl_d  = up_ctrl;
                m_data_d  = up_data;
            end else if (dn_fire) begin
                m_valid_d = 1'b0;
                m_ctrl_d  = '0;
            end
        end
    end

    always_comb begin
        up_ready_d  = ~s_valid_d;
        occupancy_d = {1'b0, m_valid_d} + {1'b0, s_valid_d};
        stall_cnt_d = stall_cnt_q;
        if (m_valid_q && !dn_ready && !flush && stall_cnt_q != CNT_MAX)
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    // State advances on the falling edge of the stage clock
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_q   <= 1'b0;
            m_ctrl_q    <= '0;
            m_data_q    <= '0;
            s_valid_q   <= 1'b0;
            s_ctrl_q    <= '0;
            s_data_q    <= '0;
            up_ready_q  <= 1'b1;
            occupancy_q <= 2'd0;
            stall_cnt_q <= '0;
        end else begin
            m_valid_q   <= m_valid_d;
            m_ctrl_q    <= m_ctrl_d;
            m_data_q    <= m_data_d;
            s_valid_q   <= s_valid_d;
            s_ctrl_q    <= s_ctrl_d;
            s_data_q    <= s_data_d;
            up_ready_q  <= up_ready_d;
            occupancy_q <= occupancy_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: a skid instance (CNT_W=4) and a pass-through
// instance (SKID=0) share stimulus; a queue-level model predicts both.
module tb_pipe_stage_skid;

    logic        clk = 1'b1;
    logic        rst_n, up_valid, dn_ready, flush;
    logic [11:0] up_ctrl;
    logic [99:0] up_data;

    logic        ur0, ur1, dv0, dv1;
    logic [11:0] dc0, dc1;
    logic [99:0] dd0, dd1;
    logic [1:0]  oc0, oc1;
    logic [3:0]  st0;
    logic [15:0] st1;

    int checks = 0;
    int errors = 0;
    bit run = 0;

    always #5 clk = ~clk;

    pipe_stage_skid #(.DATA_W(100), .CTRL_W(12), .SKID(1), .CNT_W(4)) u_skid (
        .clk(clk), .rst_n(rst_n), .up_valid(up_valid), .up_ready(ur0),
        .up_ctrl(up_ctrl), .up_data(up_data), .dn_valid(dv0), .dn_ready(dn_ready),
        .dn_ctrl(dc0), .dn_data(dd0), .flush(flush), .occupancy(oc0), .stall_cnt(st0));

    pipe_stage_skid #(.DATA_W(100), .CTRL_W(12), .SKID(0), .CNT_W(16)) u_pass (
        .clk(clk), .rst_n(rst_n), .up_valid(up_valid), .up_ready(ur1),
        .up_ctrl(up_ctrl), .up_data(up_data), .dn_valid(dv1), .dn_ready(dn_ready),
        .dn_ctrl(dc1), .dn_data(dd1), .flush(flush), .occupancy(oc1), .stall_cnt(st1));

    // Model: per instance, an ordered list of held beats (index 0 is the head)
    int          mcnt  [2];
    int          mstall[2];
    logic [11:0] mctl  [2][2];
    logic [99:0] mdat  [2][2];
    logic [99:0] mout  [2];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mcnt[k] = 0; mstall[k] = 0; mout[k] = '0;
            for (int j = 0; j < 2; j++) begin mctl[k][j] = '0; mdat[k][j] = '0; end
        end
    endtask

    function automatic bit exp_ur(input int k);
        if (k == 0) return mcnt[k] < 2;
        return (mcnt[k] == 0) || dn_ready;
    endfunction

    task automatic model_step(input int k);
        int smax = (k == 0) ? 15 : 65535;
        bit ur = exp_ur(k);
        bit df, uf;
        if (flush) begin
            mcnt[k] = 0;
        end else begin
            if (mcnt[k] > 0 && !dn_ready && mstall[k] < smax) mstall[k]++;
            df = (mcnt[k] > 0) && dn_ready;
            uf = up_valid && ur;
            if (df) begin
                mctl[k][0] = mctl[k][1]; mdat[k][0] = mdat[k][1]; mcnt[k]--;
            end
            if (uf) begin
                mctl[k][mcnt[k]] = up_ctrl; mdat[k][mcnt[k]] = up_data; mcnt[k]++;
            end
            if (mcnt[k] > 0) mout[k] = mdat[k][0];
        end
    endtask

    always @(negedge clk) if (run && rst_n) for (int k = 0; k < 2; k++) model_step(k);

    // Compare process: both instances against the model every cycle
    always @(negedge clk) begin
        #2;
        if (run) begin
            chk("skid_up_ready", ur0, exp_ur(0));
            chk("skid_dn_valid", dv0, mcnt[0] > 0);
            chk("skid_dn_ctrl",  dc0, mcnt[0] > 0 ? mctl[0][0] : 12'd0);
            chk("skid_dn_data",  dd0, mout[0]);
            chk("skid_occ",      oc0, mcnt[0]);
            chk("skid_stall",    st0, mstall[0]);
            chk("pass_up_ready", ur1, exp_ur(1));
            chk("pass_dn_valid", dv1, mcnt[1] > 0);
            chk("pass_dn_ctrl",  dc1, mcnt[1] > 0 ? mctl[1][0] : 12'd0);
            chk("pass_dn_data",  dd1, mout[1]);
            chk("pass_occ",      oc1, mcnt[1]);
            chk("pass_stall",    st1, mstall[1]);
        end
    end

    task automatic nxt();
        @(negedge clk); #3;
    endtask

    task automatic put(input bit v, input logic [11:0] c, input logic [99:0] d,
                       input bit r, input bit f);
        up_valid = v; up_ctrl = c; up_data = d; dn_ready = r; flush = f;
    endtask

    task automatic rst_pulse();
        put(0, 0, 0, 0, 0);
        rst_n = 1'b0;
        model_reset();
        #2 rst_n = 1'b1;
    endtask

    initial begin
        logic [127:0] r;
        rst_n = 1'b0;
        put(0, 0, 0, 0, 0);
        model_reset();
        run = 1;
        #7 rst_n = 1'b1;
        #1;
        chk("rst_up_ready", ur0, 1);
        chk("rst_dn_valid", dv0, 0);
        chk("rst_dn_data", dd0, 0);
        chk("rst_occ", oc0, 0);
        chk("rst_stall", st0, 0);
        chk("rst_pass_up_ready", ur1, 1);

        // Streaming at full rate
        for (int i = 1; i <= 4; i++) begin
            put(1, 12'h0A0, 100'(i), 1, 0);
            nxt();
            chk("stream_data", dd0, i);
            chk("stream_ready", ur0, 1);
            chk("stream_occ", oc0, 1);
            chk("stream_stall", st0, 0);
        end
        put(0, 0, 0, 1, 0);
        nxt();
        chk("stream_drain_valid", dv0, 0);

        // Back-pressure: A accepted, B goes to skid, C held upstream
        rst_pulse();
        put(1, 12'h00A, 100'hA, 1, 0); nxt();
        chk("bp_a", dd0, 100'hA);
        put(1, 12'h00B, 100'hB, 0, 0); nxt();
        chk("bp_occ2", oc0, 2);
        chk("bp_ready_low", ur0, 0);
        put(1, 12'h00C, 100'hC, 0, 0); nxt(); nxt();
        chk("bp_stall3", st0, 3);
        chk("bp_hold_a", dd0, 100'hA);
        put(1, 12'h00C, 100'hC, 1, 0); nxt();
        chk("bp_b", dd0, 100'hB);
        chk("bp_ready_up", ur0, 1);
        chk("bp_stall_kept", st0, 3);
        nxt();
        chk("bp_c", dd0, 100'hC);
        chk("bp_c_ctrl", dc0, 12'h00C);
        put(0, 0, 0, 1, 0); nxt();
        chk("bp_empty", dv0, 0);

        // Flush with skid full and a beat incoming
        rst_pulse();
        put(1, 12'h111, 100'h1, 0, 0); nxt();
        put(1, 12'h222, 100'h2, 0, 0); nxt();
        chk("fl_occ2", oc0, 2);
        put(1, 12'h333, 100'h3, 1, 1); nxt();
        chk("fl_valid", dv0, 0);
        chk("fl_ctrl", dc0, 0);
        chk("fl_occ", oc0, 0);
        chk("fl_data_kept", dd0, 100'h1);
        put(1, 12'h444, 100'h4, 1, 0); nxt();
        chk("fl_next_data", dd0, 100'h4);
        chk("fl_next_ctrl", dc0, 12'h444);

        // SKID=0 combinational ready
        rst_pulse();
        put(1, 12'hFFF, 100'h5, 0, 0); nxt();
        chk("p_ctrl_fff", dc1, 12'hFFF);
        up_valid = 0;
        #1 chk("p_ready_low", ur1, 0);
        dn_ready = 1;
        #1 chk("p_ready_high", ur1, 1);
        nxt();
        chk("p_ctrl_clr", dc1, 0);
        chk("p_valid_clr", dv1, 0);
        chk("p_data_kept", dd1, 100'h5);

        // Async reset in the middle of a stall
        rst_pulse();
        put(1, 12'h001, 100'h11, 0, 0); nxt();
        put(1, 12'h002, 100'h22, 0, 0);
        for (int i = 0; i < 5; i++) nxt();
        chk("ar_occ2", oc0, 2);
        chk("ar_stall5", st0, 5);
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        chk("ar_valid", dv0, 0);
        chk("ar_ctrl", dc0, 0);
        chk("ar_data", dd0, 0);
        chk("ar_occ", oc0, 0);
        chk("ar_stall", st0, 0);
        chk("ar_ready", ur0, 1);
        put(0, 0, 0, 0, 0);
        #1 rst_n = 1'b1;

        // Saturation of the 4-bit counter
        rst_pulse();
        put(1, 12'h007, 100'h77, 0, 0); nxt();
        put(0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            nxt();
            if (i == 14) chk("sat_reach", st0, 15);
        end
        chk("sat_hold", st0, 15);

        // Randomized traffic against the model
        rst_pulse();
        for (int i = 0; i < 3000; i++) begin
            r = {$urandom(), $urandom(), $urandom(), $urandom()};
            put($urandom_range(0, 9) < 7, 12'($urandom()), r[99:0],
                $urandom_range(0, 9) < 6, $urandom_range(0, 39) == 0);
            nxt();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
